// File: rtl/csub64_seq.sv
// csub64_seq: multi-cycle 64-bit subtractor, d = a - b - bi (mod 2^64).
// The operation sweeps 4-bit borrow-lookahead slices from LSB to MSB,
// NPC nibbles per clock, and keeps the inter-step borrow in a register.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands presented       in_ready  - block can accept operands
//   a, b, bi  - minuend, subtrahend, borrow-in
//   out_valid - result held              out_ready - consumer accepts result
//   d         - difference               bo        - borrow-out (a < b + bi, unsigned)
//   ovf       - signed overflow          zero      - d == 0
module csub64_seq #(
  parameter int NPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] d,
  output logic        bo,
  output logic        ovf,
  output logic        zero
);

  localparam int W     = 4 * NPC;
  localparam int STEPS = 16 / NPC;
  localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);

  generate
    if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_npc_illegal
      $error("csub64_seq: NPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_step;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        r_borrow;
  logic [63:0] r_d;
  logic        r_bo;
  logic        r_ovf;
  logic        r_zero;
  logic        r_in_ready;
  logic        r_out_valid;

  int          w_base;
  logic [W-1:0] w_a_sl;
  logic [W-1:0] w_b_sl;
  logic [W-1:0] w_step_d;
  logic        w_chain;
  logic [4:0]  w_nib;
  logic [63:0] w_d_next;

  // One nibble of borrow-lookahead subtraction: returns {borrow_out, diff[3:0]}.
  // g = ~a & b generates a borrow, p = ~(a ^ b) passes the incoming one on.
  function automatic logic [4:0] nib_sub(input logic [3:0] a4, input logic [3:0] b4,
                                         input logic b0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] br;
    g     = ~a4 & b4;
    p     = ~(a4 ^ b4);
    br[0] = b0;
    br[1] = g[0] | (p[0] & b0);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b0);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & b0);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (&p & b0);
    return {br[4], a4 ^ b4 ^ br[3:0]};
  endfunction

  // Slice datapath for the current step: NPC nibbles chained through their borrows.
  always_comb begin
    w_base   = int'(r_step) * W;
    w_a_sl   = r_a[w_base +: W];
    w_b_sl   = r_b[w_base +: W];
    w_step_d = '0;
    w_chain  = r_borrow;
    w_nib    = 5'd0;
    for (int n = 0; n < NPC; n++) begin
      w_nib                 = nib_sub(w_a_sl[4*n +: 4], w_b_sl[4*n +: 4], w_chain);
      w_step_d[4*n +: 4]    = w_nib[3:0];
      w_chain               = w_nib[4];
    end
    w_d_next                = r_d;
    w_d_next[w_base +: W]   = w_step_d;
  end

  // Control FSM with operand, borrow and result registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= 4'd0;
      r_a         <= 64'd0;
      r_b         <= 64'd0;
      r_borrow    <= 1'b0;
      r_d         <= 64'd0;
      r_bo        <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bi;
            r_step     <= 4'd0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          r_d      <= w_d_next;
          r_borrow <= w_chain;
          r_step   <= r_step + 4'd1;
          if (r_step == STEP_LAST) begin
            // Flags come from the completed difference, not the stale r_d.
            r_bo        <= w_chain;
            r_ovf       <= (r_a[63] ^ r_b[63]) & (r_a[63] ^ w_d_next[63]);
            r_zero      <= ~|w_d_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bo        = r_bo;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_csub64_seq.sv
// Directed and random checks of csub64_seq with NPC = 1, 4 and 16 instances.
module tb_csub64_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [63:0] a_s         [3];
  logic [63:0] b_s         [3];
  logic        bi_s        [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [63:0] d_s         [3];
  logic        bo_s        [3];
  logic        ovf_s       [3];
  logic        zero_s      [3];

  int checks_s;
  int fails_s;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      csub64_seq #(.NPC((g == 0) ? 1 : ((g == 1) ? 4 : 16))) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_s[g]),
        .in_ready (in_ready_s[g]),
        .a        (a_s[g]),
        .b        (b_s[g]),
        .bi       (bi_s[g]),
        .out_valid(out_valid_s[g]),
        .out_ready(out_ready_s[g]),
        .d        (d_s[g]),
        .bo       (bo_s[g]),
        .ovf      (ovf_s[g]),
        .zero     (zero_s[g])
      );
    end
  endgenerate

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_s++;
    if (got !== exp) begin
      fails_s++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 16 : ((u == 1) ? 4 : 1);
  endfunction

  task automatic start_op(input int u, input logic [63:0] a, input logic [63:0] b,
                          input logic bi);
    @(negedge clk);
    a_s[u]        = a;
    b_s[u]        = b;
    bi_s[u]       = bi;
    in_valid_s[u] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[u] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; 0 means timed out.
  task automatic wait_done(input int u, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_s[u]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume(input int u);
    @(negedge clk);
    out_ready_s[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[u] = 1'b0;
    chk("consume_ov", 64'(out_valid_s[u]), 64'd0);
  endtask

  task automatic run_op(input int u, input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic bi, input logic [63:0] ed,
                        input logic ebo, input logic eovf, input logic ezero);
    int lat;
    start_op(u, a, b, bi);
    wait_done(u, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(lat_of(u)));
    chk({tag, "_d"}, d_s[u], ed);
    chk({tag, "_bo"}, 64'(bo_s[u]), 64'(ebo));
    chk({tag, "_ovf"}, 64'(ovf_s[u]), 64'(eovf));
    chk({tag, "_zero"}, 64'(zero_s[u]), 64'(ezero));
    consume(u);
  endtask

  // Reference via wide arithmetic: unsigned 65-bit for borrow, signed 66-bit for overflow.
  task automatic run_rand(input int u);
    logic [63:0]        a;
    logic [63:0]        b;
    logic               bi;
    logic [64:0]        full;
    logic signed [65:0] sd;
    logic               eovf;
    int                 lat;
    a    = {$urandom, $urandom};
    b    = ($urandom_range(0, 15) == 0) ? a : {$urandom, $urandom};
    bi   = 1'($urandom_range(0, 1));
    full = {1'b0, a} - {1'b0, b} - {64'd0, bi};
    sd   = $signed({a[63], a[63], a}) - $signed({b[63], b[63], b}) - $signed({65'd0, bi});
    eovf = !((sd[65:63] == 3'b000) || (sd[65:63] == 3'b111));
    start_op(u, a, b, bi);
    wait_done(u, lat);
    chk("rnd_lat", 64'(lat), 64'(lat_of(u)));
    chk("rnd_d", d_s[u], full[63:0]);
    chk("rnd_bo", 64'(bo_s[u]), 64'(full[64]));
    chk("rnd_ovf", 64'(ovf_s[u]), 64'(eovf));
    consume(u);
  endtask

  initial begin
    int lat;
    checks_s = 0;
    fails_s  = 0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      a_s[i]         = 64'd0;
      b_s[i]         = 64'd0;
      bi_s[i]        = 1'b0;
    end

    // Reset asserted mid-cycle while idle.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ir", 64'(in_ready_s[0]), 64'd1);
    chk("rst_ov", 64'(out_valid_s[0]), 64'd0);
    chk("rst_d", d_s[0], 64'd0);
    chk("rst_flags", {61'd0, bo_s[0], ovf_s[0], zero_s[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, "basic", 64'h10, 64'h3, 1'b0, 64'hD, 1'b0, 1'b0, 1'b0);
    for (int u = 0; u < 3; u++)
      run_op(u, "ripple", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(1, "bin", 64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Overflow case with operand/in_valid churn in RUN and backpressure in DONE.
    start_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      a_s[0]        = {$urandom, $urandom};
      b_s[0]        = {$urandom, $urandom};
      bi_s[0]       = 1'($urandom_range(0, 1));
      in_valid_s[0] = 1'(i % 2);
      @(posedge clk);
      #1;
      if (i == 15) chk("ovf_early", 64'(out_valid_s[0]), 64'd0);
    end
    chk("ovf_ov", 64'(out_valid_s[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      a_s[0]        = {$urandom, $urandom};
      b_s[0]        = {$urandom, $urandom};
      in_valid_s[0] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("hold_d", d_s[0], 64'h7FFF_FFFF_FFFF_FFFF);
      chk("hold_flags", {60'd0, out_valid_s[0], bo_s[0], ovf_s[0], zero_s[0]}, 64'b1010);
    end

    // out_ready and in_valid together in DONE: accept only on the following IDLE edge.
    @(negedge clk);
    a_s[0]         = 64'h1234_5678_9ABC_DEF0;
    b_s[0]         = 64'h1234_5678_9ABC_DEF0;
    bi_s[0]        = 1'b0;
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    chk("both_ov", 64'(out_valid_s[0]), 64'd0);
    chk("both_ir", 64'(in_ready_s[0]), 64'd1);
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    chk("both_acc", 64'(in_ready_s[0]), 64'd0);
    wait_done(0, lat);
    chk("zero_lat", 64'(lat), 64'd16);
    chk("zero_d", d_s[0], 64'd0);
    chk("zero_flags", {61'd0, bo_s[0], ovf_s[0], zero_s[0]}, 64'b001);
    consume(0);
    @(posedge clk);
    #1;
    chk("single_op", 64'(in_ready_s[0]), 64'd1);

    // Reset at step 7 of an NPC=1 operation.
    start_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ir", 64'(in_ready_s[0]), 64'd1);
    chk("mrst_ov", 64'(out_valid_s[0]), 64'd0);
    chk("mrst_d", d_s[0], 64'd0);
    chk("mrst_flags", {61'd0, bo_s[0], ovf_s[0], zero_s[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_nores", 64'(out_valid_s[0]), 64'd0);
    run_op(0, "post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0,
           64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) run_rand(2);
    for (int i = 0; i < 50; i++) run_rand(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, fails_s);
    $finish;
  end

endmodule

// File: doc/csub64_seq.md
Name: csub64_seq

Overview:
- Multi-cycle 64-bit subtractor; the inverse-direction companion to the team's 64-bit nibble-sliced carry-lookahead adder.
- Computes d = a - b - bi by sweeping 4-bit borrow-lookahead slices from LSB to MSB.
- Processes NPC nibbles per clock, with the borrow registered between cycles.
- Sits beside the adder in the ALU datapath and is driven through a valid/ready handshake on both sides.

Parameters:
- NPC, 1, nibbles processed per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.
- Derived: STEPS = 16/NPC, the number of RUN cycles per operation.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands presented.
- in_ready, output, 1, block can accept operands.
- a, input, 64, minuend.
- b, input, 64, subtrahend.
- bi, input, 1, borrow-in.
- out_valid, output, 1, result held.
- out_ready, input, 1, consumer accepts result.
- d, output, 64, difference a - b - bi (mod 2^64).
- bo, output, 1, borrow-out; 1 iff unsigned a < b + bi.
- ovf, output, 1, signed two's-complement overflow.
- zero, output, 1, d == 0.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE and clears the step counter, the operand registers and the borrow register.
  - Outputs during reset: in_ready = 1, out_valid = 0, d = 0, bo = 0, ovf = 0, zero = 0.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: latch a, b and bi (into the borrow register), clear the step counter, go to RUN.
- RUN:
  - in_ready = 0 and out_valid = 0.
  - Each edge processes nibbles [k*NPC .. k*NPC+NPC-1], where k is the step counter.
  - Per nibble, using the incoming borrow: g_i = ~a_i & b_i, p_i = ~(a_i ^ b_i).
  - Borrows are formed lookahead-style within the nibble: B1 = g0 | p0&B0, and so on through B4.
  - Difference bits: d_i = a_i ^ b_i ^ B_i.
  - B4 of the last nibble in a step feeds the next nibble (same cycle) or the borrow register (next cycle).
  - The counter increments each edge. On the edge with k = STEPS-1, go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - d, bo, ovf and zero are stable and unchanged while out_valid = 1 and out_ready = 0.
  - bo is the final borrow.
  - ovf = (a[63] ^ b[63]) & (a[63] ^ d[63]).
  - zero = ~|d.
  - On an edge with out_ready = 1, go to IDLE. out_valid falls and the result registers keep their value.
- Latency:
  - Acceptance edge at T; out_valid is high after edge T+STEPS.
  - NPC = 1 gives 16 cycles; NPC = 16 gives 1 cycle.
  - Throughput is one operation per STEPS+2 cycles at minimum (one IDLE cycle is mandatory; no accept in DONE).
- Handshake rules:
  - in_valid is ignored outside IDLE, and operand changes outside IDLE have no effect.
  - out_ready is ignored outside DONE.
  - in_valid and out_ready may both be high in DONE: the result is consumed and the new operand is not accepted until the following IDLE edge.
  - in_valid must not depend combinationally on in_ready.
- Width and arithmetic:
  - All arithmetic is mod 2^64; there is no saturation.
  - bi = 1 with a = b gives d = all-ones and bo = 1.
- The d register may be updated nibble-wise during RUN. Its value is only defined while out_valid = 1.

Test Plan:
- Reset then basic subtraction, NPC = 1:
  - Assert rst_n = 0 mid-idle → in_ready = 1, out_valid = 0, d = 0.
  - Then present a = 0x10, b = 0x3, bi = 0 → out_valid rises 16 edges after the accept edge, d = 0xD, bo = 0, ovf = 0, zero = 0.
- Full borrow ripple: a = 0, b = 1, bi = 0 → d = 0xFFFFFFFFFFFFFFFF, bo = 1, ovf = 0, zero = 0.
  - Repeat with NPC = 1, 4 and 16; latency must be 16, 4 and 1 cycles respectively.
- Signed overflow and zero:
  - a = 0x8000000000000000, b = 1 → d = 0x7FFFFFFFFFFFFFFF, ovf = 1, bo = 0.
  - a = b = 0x123456789ABCDEF0, bi = 0 → d = 0, zero = 1, bo = 0.
- Borrow-in: a = 5, b = 5, bi = 1 → d = 0xFFFFFFFFFFFFFFFF, bo = 1, zero = 0.
- Backpressure and handshake:
  - Hold out_ready = 0 for 10 cycles in DONE → d and flags remain stable.
  - Toggle a, b and in_valid during RUN and DONE → no effect on the result.
  - Raise out_ready together with in_valid → exactly one new operation starts, after the IDLE edge.
- Reset mid-RUN and random check:
  - Drop rst_n at step 7 → outputs return to reset values immediately; after release the next operation completes correctly.
  - Run 10k random a, b, bi → d, bo and ovf match the reference model {bo, d} = {1'b0, a} - b - bi.
